team_08_tft_compositor: RTL and testbench
=========================================

# team_08_tft_compositor

Pixel-source controller for the team_08 ILI9341 frame-buffer driver. It tracks the driver's raster position from the driver's pixel-request strobe and returns one RGB565 word per pixel. Each word comes from a small set of rectangles, or from a background colour where no rectangle covers the pixel. Several game-logic requesters share the single rectangle-register write port through a round-robin arbiter.

## Interface
Parameters:
- NUM_REQ, 4: requesters; requester i owns rectangle slot i.
- H_RES, 320: pixels per line.
- V_RES, 240: lines per frame.

Ports:
- clk  in  1  system clock, same clock as the TFT driver.
- nrst  in  1  asynchronous, active-low reset.
- fb_clk  in  1  driver pixel-request strobe, registered in the clk domain.
- tft_state  in  3  driver state; value 3'd4 = LOOP.
- bg_color  in  16  RGB565 background colour.
- upd_valid  in  NUM_REQ  per-requester write request.
- upd_ready  out  NUM_REQ  per-requester grant; one-hot or zero.
- upd_en  in  NUM_REQ  per-requester rectangle enable.
- upd_x0, upd_x1  in  9*NUM_REQ  inclusive column bounds, packed by requester.
- upd_y0, upd_y1  in  8*NUM_REQ  inclusive row bounds, packed by requester.
- upd_color  in  16*NUM_REQ  rectangle colour, packed by requester.
- pixel_data  out  16  word for the current pixel; goes to the driver's framebufferData.
- cur_x  out  9  current column.
- cur_y  out  8  current row.
- frame_start  out  1  one-cycle pulse at each frame start.

## Operation
- Reset values:
  - all outputs 0;
  - all slots disabled;
  - round-robin pointer at 0.
- Raster:
  - While tft_state != LOOP, cur_x and cur_y are held at 0 and fb_clk edges are ignored.
  - Each fb_clk rising edge seen in LOOP advances the position.
  - cur_x wraps from H_RES-1 to 0 and increments cur_y.
  - Wrap from (H_RES-1, V_RES-1) goes to (0,0).
- frame_start pulses on:
  - entry into LOOP;
  - each wrap to (0,0).
- Compositing:
  - A pixel is covered by slot k when en_k, x0_k ≤ x ≤ x1_k and y0_k ≤ y ≤ y1_k.
  - If x0 > x1 or y0 > y1, the slot covers nothing.
  - The lowest covering slot index wins; no coverage gives bg_color.
  - All compares are unsigned.
- Arbitration:
  - Each cycle, at most one upd_ready bit is high: the first requester with upd_valid set, searching from the pointer.
  - A transfer happens when upd_valid[i] & upd_ready[i]; all five fields of slot i are written together.
  - After a transfer the pointer moves to i+1 mod NUM_REQ.
  - The pointer does not move on idle cycles.
  - upd_ready is combinational from upd_valid and the pointer; a requester holds valid and data until it sees ready.

## Timing
- fb_clk is edge-detected with one register stage.
- The position advances in the cycle after the edge is detected.
- pixel_data is registered. It reflects the new position exactly 2 clk cycles after the first cycle fb_clk is sampled high.
- pixel_data then holds until the next advance. The driver's 9-clock SPI byte time covers this latency.
- After a transfer, the slot affects pixel_data no earlier than the next pixel advance (without TFT_FRAME_SYNC_EN).
- A transfer in the same cycle as an advance is visible from the following pixel.
- Reset mid-frame returns the raster to (0,0) and disables all slots; the next LOOP entry pulses frame_start.

## Configuration
- TFT_FRAME_SYNC_EN defined:
  - transfers write shadow slots;
  - all shadow slots copy to the active slots in the cycle the raster wraps to (0,0);
  - a transfer in that same cycle lands in the shadow only and shows on the following frame;
  - there is no mid-frame tearing.
- Undefined: transfers write the active slots directly, with the timing above.

## Structure
- Package team_08_tft_pkg holds:
  - rect_t struct (en, x0, x1, y0, y1, color);
  - H_RES and V_RES defaults;
  - TFT_STATE_LOOP = 3'd4.
- One sub-module: team_08_rr_arbiter, the NUM_REQ-wide round-robin grant with its pointer register.

## Test plan
- Start-up: hold tft_state = 1, pulse fb_clk → cur_x = 0, cur_y = 0, no frame_start. Set tft_state = 4 → one frame_start pulse.
- Background only: bg_color = 16'h001F, no slots, 320×240 fb_clk strobes → every pixel_data = 001F; cur_x/cur_y wrap at (319,239); frame_start pulses once per frame.
- Overlap priority:
  - setup: slot0 (10..19, 5..9, F800), slot1 (15..30, 5..5, 07E0);
  - pixel (15,5) → F800;
  - pixel (25,5) → 07E0;
  - pixel (25,6) → bg_color.
- Arbitration: upd_valid = 4'b1011 held for three cycles with the pointer at 0 → grants 0, then 1, then 3 in successive cycles.
- Empty and boundary rectangles:
  - x0 = 20, x1 = 10 → never covers;
  - x0 = x1 = 319, y0 = y1 = 239 → covers only the last pixel of the frame.
- With TFT_FRAME_SYNC_EN: write slot0 at pixel (100,50) → no change until the next frame. A write in the same cycle as the wrap appears one frame later. Without the macro, the write shows from the next pixel.

Source files
------------

// File: rtl/team_08_tft_pkg.sv
// Shared types and constants for the team_08 TFT pixel-source controller.
// Rectangle slot layout, default raster size and the driver LOOP state code.
package team_08_tft_pkg;

    localparam int DEFAULT_H_RES = 320;
    localparam int DEFAULT_V_RES = 240;

    localparam logic [2:0] TFT_STATE_LOOP = 3'd4;

    typedef struct packed {
        logic        en;
        logic [8:0]  x0;
        logic [8:0]  x1;
        logic [7:0]  y0;
        logic [7:0]  y1;
        logic [15:0] color;
    } rect_t;

    // Inclusive unsigned bounds; an inverted range can never match.
    function automatic logic rect_covers(input rect_t r, input logic [8:0] x, input logic [7:0] y);
        return r.en && (x >= r.x0) && (x <= r.x1) && (y >= r.y0) && (y <= r.y1);
    endfunction

endpackage

// File: rtl/team_08_rr_arbiter.sv
// Round-robin grant for the shared rectangle write port.
// Grants the first requester at or after the pointer; pointer moves past the winner.
module team_08_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PW-1:0]      gnt_idx,
    output logic               gnt_any
);

    logic [PW-1:0] ptr;
    int unsigned   idx;

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
        gnt = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/team_08_tft_compositor.sv
// Raster tracker and rectangle compositor feeding the ILI9341 framebufferData.
// Optional macro TFT_FRAME_SYNC_EN: writes go to shadow slots copied in at each frame wrap.
module team_08_tft_compositor
    import team_08_tft_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int H_RES   = DEFAULT_H_RES,
    parameter int V_RES   = DEFAULT_V_RES
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  fb_clk,
    input  logic [2:0]            tft_state,
    input  logic [15:0]           bg_color,
    input  logic [NUM_REQ-1:0]    upd_valid,
    output logic [NUM_REQ-1:0]    upd_ready,
    input  logic [NUM_REQ-1:0]    upd_en,
    input  logic [9*NUM_REQ-1:0]  upd_x0,
    input  logic [9*NUM_REQ-1:0]  upd_x1,
    input  logic [8*NUM_REQ-1:0]  upd_y0,
    input  logic [8*NUM_REQ-1:0]  upd_y1,
    input  logic [16*NUM_REQ-1:0] upd_color,
    output logic [15:0]           pixel_data,
    output logic [8:0]            cur_x,
    output logic [7:0]            cur_y,
    output logic                  frame_start
);

    localparam int AW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic          loop, loop_q, fb_prev, adv, load_pix;
    logic          end_x, end_y, frame_wrap;
    logic [AW-1:0] gnt_idx;
    logic          gnt_any;
    rect_t         wr_rect;
    rect_t         act [NUM_REQ];
    logic [15:0]   comp;

    team_08_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (AW)
    ) u_arb (
        .clk     (clk),
        .nrst    (nrst),
        .req     (upd_valid),
        .gnt     (upd_ready),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign loop       = (tft_state == TFT_STATE_LOOP);
    assign end_x      = (cur_x == 9'(H_RES - 1));
    assign end_y      = (cur_y == 8'(V_RES - 1));
    assign frame_wrap = adv && loop && end_x && end_y;

    always_comb begin
        wr_rect.en    = upd_en[gnt_idx];
        wr_rect.x0    = upd_x0[9*gnt_idx +: 9];
        wr_rect.x1    = upd_x1[9*gnt_idx +: 9];
        wr_rect.y0    = upd_y0[8*gnt_idx +: 8];
        wr_rect.y1    = upd_y1[8*gnt_idx +: 8];
        wr_rect.color = upd_color[16*gnt_idx +: 16];
    end

    // Walk from the highest slot down so the lowest covering index lands last.
    always_comb begin
        comp = bg_color;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            if (rect_covers(act[k-1], cur_x, cur_y)) comp = act[k-1].color;
        end
    end

    // adv is the registered edge; the position moves one cycle later and
    // pixel_data is reloaded the cycle after that, then held.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fb_prev     <= 1'b0;
            loop_q      <= 1'b0;
            adv         <= 1'b0;
            load_pix    <= 1'b0;
            frame_start <= 1'b0;
            cur_x       <= '0;
            cur_y       <= '0;
            pixel_data  <= '0;
        end else begin
            fb_prev     <= fb_clk;
            loop_q      <= loop;
            adv         <= loop && fb_clk && !fb_prev;
            load_pix    <= (adv && loop) || (loop && !loop_q);
            frame_start <= (loop && !loop_q) || frame_wrap;
            if (!loop) begin
                cur_x <= '0;
                cur_y <= '0;
            end else if (adv) begin
                if (end_x) begin
                    cur_x <= '0;
                    cur_y <= end_y ? '0 : cur_y + 8'd1;
                end else begin
                    cur_x <= cur_x + 9'd1;
                end
            end
            if (load_pix) pixel_data <= comp;
        end
    end

`ifdef TFT_FRAME_SYNC_EN
    rect_t shd [NUM_REQ];

    // The copy samples the shadow before this cycle's write, so a write
    // coinciding with the wrap waits for the following frame.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                act[k] <= '0;
                shd[k] <= '0;
            end
        end else begin
            if (frame_wrap) act <= shd;
            if (gnt_any) shd[gnt_idx] <= wr_rect;
        end
    end
`else
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                act[k] <= '0;
            end
        end else if (gnt_any) begin
            act[gnt_idx] <= wr_rect;
        end
    end
`endif

endmodule

// File: tb/tb_team_08_tft_compositor.sv
// Scoreboard bench for team_08_tft_compositor on a reduced 32x12 raster.
// Honours TFT_FRAME_SYNC_EN in its slot model when the macro is defined.
module tb_team_08_tft_compositor;

    localparam int NR = 4;
    localparam int H  = 32;
    localparam int V  = 12;

    logic           clk = 1'b0;
    logic           nrst;
    logic           fb_clk;
    logic [2:0]     tft_state;
    logic [15:0]    bg_color;
    logic [NR-1:0]  upd_valid, upd_ready, upd_en;
    logic [9*NR-1:0]  upd_x0, upd_x1;
    logic [8*NR-1:0]  upd_y0, upd_y1;
    logic [16*NR-1:0] upd_color;
    logic [15:0]    pixel_data;
    logic [8:0]     cur_x;
    logic [7:0]     cur_y;
    logic           frame_start;

    team_08_tft_compositor #(.NUM_REQ(NR), .H_RES(H), .V_RES(V)) dut (
        .clk(clk), .nrst(nrst), .fb_clk(fb_clk), .tft_state(tft_state),
        .bg_color(bg_color), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_en(upd_en), .upd_x0(upd_x0), .upd_x1(upd_x1), .upd_y0(upd_y0),
        .upd_y1(upd_y1), .upd_color(upd_color), .pixel_data(pixel_data),
        .cur_x(cur_x), .cur_y(cur_y), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; logic [15:0] d; } px_t;
    typedef struct { bit en; int x0; int x1; int y0; int y1; logic [15:0] c; } mrect_t;

    px_t            pq[$];
    logic [NR-1:0]  gq[$];
    mrect_t         m_sh[NR];
    mrect_t         m_act[NR];
    int             tb_x, tb_y;
    int             checks = 0;
    int             failures = 0;
    int             fs_cnt = 0;
    bit             fbp, s1, s2, s3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input int x, input int y);
        for (int k = 0; k < NR; k++)
            if (m_act[k].en && x >= m_act[k].x0 && x <= m_act[k].x1 &&
                y >= m_act[k].y0 && y <= m_act[k].y1)
                return m_act[k].c;
        return bg_color;
    endfunction

    // Independent 2-cycle delay line from the sampled fb_clk edge to the data.
    always @(posedge clk) begin
        fbp <= fb_clk;
        s1  <= fb_clk && !fbp && (tft_state == 3'd4) && nrst;
        s2  <= s1;
        s3  <= s2;
    end

    always @(negedge clk) begin
        px_t e;
        if (frame_start === 1'b1) fs_cnt++;
        if (s3) begin
            checks++;
            if (pq.size() == 0) begin
                failures++;
                $display("FAIL pix_unexpected: got (%0d,%0d)=%h expected no pixel", cur_x, cur_y, pixel_data);
            end else begin
                e = pq.pop_front();
                if (cur_x !== 9'(e.x) || cur_y !== 8'(e.y) || pixel_data !== e.d) begin
                    failures++;
                    $display("FAIL pixel: got (%0d,%0d)=%h expected (%0d,%0d)=%h",
                             cur_x, cur_y, pixel_data, e.x, e.y, e.d);
                end
            end
        end
        if (gq.size() > 0) begin
            logic [NR-1:0] g;
            g = gq.pop_front();
            checks++;
            if (upd_ready !== g) begin
                failures++;
                $display("FAIL grant: got %b expected %b", upd_ready, g);
            end
        end
    end

    task automatic step();
        px_t e;
        tb_x++;
        if (tb_x == H) begin
            tb_x = 0;
            tb_y++;
            if (tb_y == V) begin
                tb_y = 0;
`ifdef TFT_FRAME_SYNC_EN
                m_act = m_sh;
`endif
            end
        end
        e.x = tb_x; e.y = tb_y; e.d = model(tb_x, tb_y);
        pq.push_back(e);
        @(posedge clk); #2 fb_clk = 1'b1;
        @(posedge clk); #2 fb_clk = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(negedge clk);
        chk("queue_drained", pq.size(), 0);
    endtask

    task automatic set_req(input int i, input bit en, input int x0, input int x1,
                           input int y0, input int y1, input logic [15:0] c);
        upd_en[i] = en;
        upd_x0[9*i +: 9] = 9'(x0);
        upd_x1[9*i +: 9] = 9'(x1);
        upd_y0[8*i +: 8] = 8'(y0);
        upd_y1[8*i +: 8] = 8'(y1);
        upd_color[16*i +: 16] = c;
        m_sh[i] = '{en, x0, x1, y0, y1, c};
    endtask

    task automatic commit(input int i);
`ifndef TFT_FRAME_SYNC_EN
        m_act[i] = m_sh[i];
`endif
    endtask

    task automatic write_slot(input int i, input bit en, input int x0, input int x1,
                              input int y0, input int y1, input logic [15:0] c);
        bit got = 0;
        set_req(i, en, x0, x1, y0, y1, c);
        @(posedge clk); #2 upd_valid[i] = 1'b1;
        for (int n = 0; n < 16 && !got; n++) begin
            @(negedge clk);
            if (upd_ready[i]) got = 1;
        end
        chk("write_granted", 32'(got), 1);
        @(posedge clk); #2 upd_valid[i] = 1'b0;
        commit(i);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0; fb_clk = 1'b0; tft_state = 3'd1; bg_color = 16'h001F;
        upd_valid = '0; upd_en = '0; upd_x0 = '0; upd_x1 = '0;
        upd_y0 = '0; upd_y1 = '0; upd_color = '0;
        for (int k = 0; k < NR; k++) m_sh[k] = '{0, 0, 0, 0, 0, 16'h0};
        m_act = m_sh;
        tb_x = 0; tb_y = 0;

        repeat (3) @(negedge clk);
        chk("rst_pixel", pixel_data, 0);
        chk("rst_x", cur_x, 0);
        chk("rst_y", cur_y, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_ready", upd_ready, 0);
        @(posedge clk); #2 nrst = 1'b1;

        // fb_clk strobes outside LOOP must not move the raster
        repeat (3) begin
            @(posedge clk); #2 fb_clk = 1'b1;
            @(posedge clk); #2 fb_clk = 1'b0;
        end
        repeat (4) @(negedge clk);
        chk("idle_x", cur_x, 0);
        chk("idle_y", cur_y, 0);
        chk("idle_fs", fs_cnt, 0);

        @(posedge clk); #2 tft_state = 3'd4;
        repeat (4) @(negedge clk);
        chk("entry_fs", fs_cnt, 1);
        chk("entry_pixel", pixel_data, 16'h001F);
        chk("entry_x", cur_x, 0);

        // Frame 1: background only, wraps at (31,11)
        repeat (H*V) step();
        drain();
        chk("frame1_fs", fs_cnt, 2);

        // Frame 2: overlapping slots 0 and 1
        write_slot(0, 1, 10, 19, 5, 9, 16'hF800);
        write_slot(1, 1, 15, 30, 5, 5, 16'h07E0);
        repeat (H*V) step();
        drain();
        chk("frame2_fs", fs_cnt, 3);

        // Leave the pointer at 0: slot2 boundary pixel, slot3 inverted x
        write_slot(2, 1, 31, 31, 11, 11, 16'h1234);
        write_slot(3, 1, 20, 10, 0, 11, 16'hFFFF);

        set_req(3, 1, 0, 31, 9, 3, 16'hEEEE);
        @(posedge clk); #2 upd_valid = 4'b1011;
        gq.push_back(4'b0001); gq.push_back(4'b0010);
        gq.push_back(4'b1000); gq.push_back(4'b0000);
        repeat (3) @(posedge clk);
        #2 upd_valid = 4'b0000;
        commit(0); commit(1); commit(3);
        repeat (3) @(posedge clk);
        #2 upd_valid = 4'b0110;
        gq.push_back(4'b0010);
        @(posedge clk); #2 upd_valid = 4'b0000;
        repeat (2) @(negedge clk);
        chk("grant_drained", gq.size(), 0);

        // Frame 3: empty rectangles, single-pixel slot at the last pixel
        repeat (H*V) step();
        drain();
        chk("frame3_fs", fs_cnt, 4);

        // New slot data holds off until the next pixel advance
        repeat (2*H + 4) step();
        drain();
        chk("hold_before", pixel_data, 16'h001F);
        write_slot(0, 1, 0, 31, 0, 11, 16'hABCD);
        repeat (3) @(negedge clk);
        chk("hold_after_write", pixel_data, 16'h001F);
        repeat (3) step();
        drain();

        // Mid-frame reset clears raster and slots
        @(posedge clk); #2 nrst = 1'b0; tft_state = 3'd1;
        @(negedge clk);
        chk("mid_rst_x", cur_x, 0);
        chk("mid_rst_y", cur_y, 0);
        chk("mid_rst_pixel", pixel_data, 0);
        @(posedge clk); #2 nrst = 1'b1;
        for (int k = 0; k < NR; k++) m_sh[k] = '{0, 0, 0, 0, 0, 16'h0};
        m_act = m_sh;
        tb_x = 0; tb_y = 0;
        @(posedge clk); #2 tft_state = 3'd4;
        repeat (4) @(negedge clk);
        chk("reentry_fs", fs_cnt, 5);
        chk("reentry_pixel", pixel_data, 16'h001F);
        repeat (4) step();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
